// File: rtl/chip8_cpu.sv
`default_nettype none
// ============================================================================
// Module      : chip8_cpu (with internal RAM chip8_ram)
// Description : CHIP-8 instruction-set processor core with an internal
//               4096x8 single-port RAM. Programs start at PROG_START and the
//               core halts on opcode 0x0000. The 64x32 monochrome frame
//               buffer occupies RAM bytes FB_BASE..FB_BASE+255 (row-major,
//               one bit per pixel, MSB = leftmost pixel).
// Ports       : clk   - system clock, all state changes on the rising edge
//               reset - synchronous, active-high reset
//               pc    - program counter (address of next instruction fetch)
// Option      : CPU_RAND_EN - when defined, CXNN draws from a 16-bit LFSR;
//               when undefined, CXNN writes 0 and no LFSR is built.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// chip8_ram: 4096x8 single-port RAM, synchronous read and write. The read
// port returns the old contents on a simultaneous write to the same address.
// ----------------------------------------------------------------------------
module chip8_ram (
  input  logic        clk,
  input  logic        i_we,
  input  logic [11:0] i_addr,
  input  logic [7:0]  i_wdata,
  output logic [7:0]  o_rdata
);

  logic [7:0] data [0:4095];

  always_ff @(posedge clk) begin
    if (i_we) begin
      data[i_addr] <= i_wdata;
    end
    o_rdata <= data[i_addr];
  end

endmodule

module chip8_cpu #(
  parameter logic [11:0] PROG_START = 12'h200,
  parameter logic [11:0] FB_BASE    = 12'h100
) (
  input  logic        clk,
  input  logic        reset,
  output logic [11:0] pc
);

  localparam logic [2:0] STATE_FETCH_HI = 3'd0;
  localparam logic [2:0] STATE_FETCH_LO = 3'd1;
  localparam logic [2:0] STATE_EXEC     = 3'd2;
  localparam logic [2:0] STATE_CLEAR    = 3'd3;
  localparam logic [2:0] STATE_BCD      = 3'd4;
  localparam logic [2:0] STATE_STORE    = 3'd5;
  localparam logic [2:0] STATE_LOAD     = 3'd6;
  localparam logic [2:0] STATE_IDLE     = 3'd7;

  // Architectural state
  logic [2:0]  state;
  logic [11:0] addr;              // index register I
  logic [3:0]  sp;
  logic [7:0]  r_v     [0:15];
  logic [11:0] r_stack [0:15];

  // Sequencing state
  logic [7:0]  r_hi;              // latched high opcode byte
  logic [7:0]  r_cnt;             // step counter for multi-cycle ops
  logic [3:0]  r_x;               // X field kept for multi-cycle ops

  // RAM interface
  logic        w_ram_we;
  logic [11:0] w_ram_addr;
  logic [7:0]  w_ram_wdata;
  logic [7:0]  w_rd;

  chip8_ram mem0 (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_rd)
  );

  // --------------------------------------------------------------------------
  // Instruction decode. In STATE_EXEC the low byte comes straight from the
  // RAM read data, so the opcode is only meaningful in that state.
  // --------------------------------------------------------------------------
  logic [15:0] w_op;
  logic [3:0]  w_x;
  logic [3:0]  w_y;
  logic [3:0]  w_n;
  logic [7:0]  w_nn;
  logic [11:0] w_nnn;
  logic [7:0]  w_vx;
  logic [7:0]  w_vy;
  logic [11:0] w_pc2;
  logic [11:0] w_pc4;
  logic [3:0]  w_sp_dec;
  logic [7:0]  w_rand;

  assign w_op     = {r_hi, w_rd};
  assign w_x      = w_op[11:8];
  assign w_y      = w_op[7:4];
  assign w_n      = w_op[3:0];
  assign w_nn     = w_op[7:0];
  assign w_nnn    = w_op[11:0];
  assign w_vx     = r_v[w_x];
  assign w_vy     = r_v[w_y];
  assign w_pc2    = pc + 12'd2;
  assign w_pc4    = pc + 12'd4;
  assign w_sp_dec = sp - 4'd1;

`ifdef CPU_RAND_EN
  // Fibonacci LFSR x^16+x^14+x^13+x^11+1 in right-shift form; free-running.
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_rand    = r_lfsr[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
    end
  end
`else
  assign w_rand = 8'h00;
`endif

  // --------------------------------------------------------------------------
  // 8XYn arithmetic/logic unit
  // --------------------------------------------------------------------------
  logic [7:0] w_alu_res;
  logic       w_alu_flag;
  logic       w_alu_wf;           // this op writes VF
  logic       w_alu_ok;           // recognised 8XYn variant
  logic [8:0] w_sum;

  assign w_sum = {1'b0, w_vx} + {1'b0, w_vy};

  always_comb begin
    w_alu_res  = w_vy;
    w_alu_flag = 1'b0;
    w_alu_wf   = 1'b0;
    w_alu_ok   = 1'b1;
    case (w_n)
      4'h0: w_alu_res = w_vy;
      4'h1: w_alu_res = w_vx | w_vy;
      4'h2: w_alu_res = w_vx & w_vy;
      4'h3: w_alu_res = w_vx ^ w_vy;
      4'h4: begin
        w_alu_res  = w_sum[7:0];
        w_alu_flag = w_sum[8];
        w_alu_wf   = 1'b1;
      end
      4'h5: begin
        w_alu_res  = w_vx - w_vy;
        w_alu_flag = (w_vx >= w_vy);
        w_alu_wf   = 1'b1;
      end
      4'h6: begin
        w_alu_res  = {1'b0, w_vx[7:1]};
        w_alu_flag = w_vx[0];
        w_alu_wf   = 1'b1;
      end
      4'h7: begin
        w_alu_res  = w_vy - w_vx;
        w_alu_flag = (w_vy >= w_vx);
        w_alu_wf   = 1'b1;
      end
      4'hE: begin
        w_alu_res  = {w_vx[6:0], 1'b0};
        w_alu_flag = w_vx[7];
        w_alu_wf   = 1'b1;
      end
      default: w_alu_ok = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // BCD digits of the register captured at FX33 execution
  // --------------------------------------------------------------------------
  logic [7:0] w_vr;
  logic [7:0] w_hund;
  logic [7:0] w_tens;
  logic [7:0] w_ones;

  assign w_vr   = r_v[r_x];
  assign w_hund = w_vr / 8'd100;
  assign w_tens = (w_vr / 8'd10) % 8'd10;
  assign w_ones = w_vr % 8'd10;

  // --------------------------------------------------------------------------
  // RAM address/write mux. The address is combinational from registered
  // state so that the synchronous read returns data in the following state.
  // --------------------------------------------------------------------------
  logic [11:0] w_step_addr;
  assign w_step_addr = addr + {4'b0000, r_cnt};

  always_comb begin
    w_ram_addr  = pc;
    w_ram_we    = 1'b0;
    w_ram_wdata = 8'h00;
    case (state)
      STATE_FETCH_HI: w_ram_addr = pc;
      STATE_FETCH_LO: w_ram_addr = pc + 12'd1;
      STATE_CLEAR: begin
        w_ram_addr  = FB_BASE + {4'b0000, r_cnt};
        w_ram_we    = 1'b1;
        w_ram_wdata = 8'h00;
      end
      STATE_BCD: begin
        w_ram_addr = w_step_addr;
        w_ram_we   = 1'b1;
        case (r_cnt[1:0])
          2'd0:    w_ram_wdata = w_hund;
          2'd1:    w_ram_wdata = w_tens;
          default: w_ram_wdata = w_ones;
        endcase
      end
      STATE_STORE: begin
        w_ram_addr  = w_step_addr;
        w_ram_we    = 1'b1;
        w_ram_wdata = r_v[r_cnt[3:0]];
      end
      STATE_LOAD: w_ram_addr = w_step_addr;
      default:    w_ram_addr = pc;
    endcase
    // A reset cycle aborts the instruction, including its pending write.
    if (reset) begin
      w_ram_we = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Main sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= STATE_FETCH_HI;
      pc    <= PROG_START;
      addr  <= 12'h000;
      sp    <= 4'h0;
      r_hi  <= 8'h00;
      r_cnt <= 8'h00;
      r_x   <= 4'h0;
      for (int i = 0; i < 16; i++) begin
        r_v[i] <= 8'h00;
      end
    end else begin
      case (state)
        STATE_FETCH_HI: state <= STATE_FETCH_LO;

        STATE_FETCH_LO: begin
          r_hi  <= w_rd;
          state <= STATE_EXEC;
        end

        STATE_EXEC: begin
          pc    <= w_pc2;
          state <= STATE_FETCH_HI;
          r_cnt <= 8'h00;
          r_x   <= w_x;
          case (w_op[15:12])
            4'h0: begin
              if (w_op == 16'h0000) begin
                state <= STATE_IDLE;
              end else if (w_op == 16'h00E0) begin
                state <= STATE_CLEAR;
              end else if (w_op == 16'h00EE) begin
                sp <= w_sp_dec;
                pc <= r_stack[w_sp_dec];
              end
            end
            4'h1: pc <= w_nnn;
            4'h2: begin
              r_stack[sp] <= w_pc2;
              sp          <= sp + 4'd1;
              pc          <= w_nnn;
            end
            4'h3: if (w_vx == w_nn) pc <= w_pc4;
            4'h4: if (w_vx != w_nn) pc <= w_pc4;
            4'h5: if (w_n == 4'h0 && w_vx == w_vy) pc <= w_pc4;
            4'h6: r_v[w_x] <= w_nn;
            4'h7: r_v[w_x] <= w_vx + w_nn;
            4'h8: begin
              if (w_alu_ok) begin
                r_v[w_x] <= w_alu_res;
                // Placed after the Vx write so VF as destination takes the flag.
                if (w_alu_wf) begin
                  r_v[15] <= {7'b0000000, w_alu_flag};
                end
              end
            end
            4'h9: if (w_n == 4'h0 && w_vx != w_vy) pc <= w_pc4;
            4'hA: addr <= w_nnn;
            4'hB: pc <= w_nnn + {4'b0000, r_v[0]};
            4'hC: r_v[w_x] <= w_rand & w_nn;
            4'hF: begin
              case (w_nn)
                8'h1E:   addr  <= addr + {4'b0000, w_vx};
                8'h33:   state <= STATE_BCD;
                8'h55:   state <= STATE_STORE;
                8'h65:   state <= STATE_LOAD;
                default: state <= STATE_FETCH_HI;
              endcase
            end
            default: state <= STATE_FETCH_HI;
          endcase
        end

        STATE_CLEAR: begin
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == 8'hFF) begin
            state <= STATE_FETCH_HI;
          end
        end

        STATE_BCD: begin
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == 8'd2) begin
            state <= STATE_FETCH_HI;
          end
        end

        STATE_STORE: begin
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == {4'b0000, r_x}) begin
            state <= STATE_FETCH_HI;
          end
        end

        // Step k issues the read of addr+k and retires the read of step k-1.
        STATE_LOAD: begin
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt != 8'h00) begin
            r_v[r_cnt[3:0] - 4'd1] <= w_rd;
          end
          if (r_cnt == ({4'b0000, r_x} + 8'd1)) begin
            state <= STATE_FETCH_HI;
          end
        end

        STATE_IDLE: state <= STATE_IDLE;

        default: state <= STATE_FETCH_HI;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chip8_cpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_chip8_cpu
// Description : Self-checking bench for chip8_cpu. Programs are executed by an
//               instruction-level reference interpreter and the DUT's final
//               pc, I, sp, cycle count and whole RAM image are compared.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chip8_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] pc;

  chip8_cpu dut (
    .clk   (clk),
    .reset (reset),
    .pc    (pc)
  );

  always #5 clk = ~clk;

  // Encodings of the two states the bench observes directly.
  localparam logic [2:0] S_FETCH_HI = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd7;

  int n_checks = 0;
  int n_errors = 0;
  int dut_cyc;

  logic [7:0]  init_mem [0:4095];

  // Reference interpreter state
  logic [7:0]  mm   [0:4095];
  logic [7:0]  mv   [0:15];
  logic [11:0] mstk [0:15];
  logic [11:0] mi;
  logic [11:0] mpc;
  logic [3:0]  msp;
  int          mcyc;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic put(input int a, input logic [15:0] w);
    init_mem[a % 4096]       = w[15:8];
    init_mem[(a + 1) % 4096] = w[7:0];
  endtask

  task automatic fill_random();
    for (int i = 0; i < 4096; i++) init_mem[i] = 8'($urandom);
  endtask

  // Instruction-level interpreter with a per-instruction clock cost.
  task automatic model_run();
    logic [15:0] op;
    int x, y, n, nn, nnn, a, b, r, f, wf, ok;
    for (int i = 0; i < 4096; i++) mm[i] = init_mem[i];
    for (int i = 0; i < 16; i++) mv[i] = 8'h00;
    mi = 12'h000; mpc = 12'h200; msp = 4'h0; mcyc = 0;
    for (int step = 0; step < 4000; step++) begin
      op  = {mm[mpc], mm[(int'(mpc) + 1) % 4096]};
      mpc = 12'((int'(mpc) + 2) % 4096);
      mcyc += 3;
      x = int'(op[11:8]); y = int'(op[7:4]); n = int'(op[3:0]);
      nn = int'(op[7:0]); nnn = int'(op[11:0]);
      a = int'(mv[x]); b = int'(mv[y]);
      case (op[15:12])
        4'h0: begin
          if (op == 16'h0000) break;
          if (op == 16'h00E0) begin
            for (int k = 0; k < 256; k++) mm[256 + k] = 8'h00;
            mcyc += 256;
          end else if (op == 16'h00EE) begin
            msp = msp - 4'd1;
            mpc = mstk[msp];
          end
        end
        4'h1: mpc = 12'(nnn);
        4'h2: begin mstk[msp] = mpc; msp = msp + 4'd1; mpc = 12'(nnn); end
        4'h3: if (a == nn) mpc = 12'((int'(mpc) + 2) % 4096);
        4'h4: if (a != nn) mpc = 12'((int'(mpc) + 2) % 4096);
        4'h5: if (n == 0 && a == b) mpc = 12'((int'(mpc) + 2) % 4096);
        4'h9: if (n == 0 && a != b) mpc = 12'((int'(mpc) + 2) % 4096);
        4'h6: mv[x] = 8'(nn);
        4'h7: mv[x] = 8'((a + nn) % 256);
        4'h8: begin
          ok = 1; wf = 0; f = 0; r = 0;
          case (n)
            0: r = b;
            1: r = a | b;
            2: r = a & b;
            3: r = a ^ b;
            4: begin r = (a + b) % 256; f = (a + b > 255) ? 1 : 0; wf = 1; end
            5: begin r = (a - b + 256) % 256; f = (a >= b) ? 1 : 0; wf = 1; end
            6: begin r = a / 2; f = a % 2; wf = 1; end
            7: begin r = (b - a + 256) % 256; f = (b >= a) ? 1 : 0; wf = 1; end
            14: begin r = (a * 2) % 256; f = (a >= 128) ? 1 : 0; wf = 1; end
            default: ok = 0;
          endcase
          if (ok != 0) begin
            mv[x] = 8'(r);
            if (wf != 0) mv[15] = 8'(f);
          end
        end
        4'hA: mi = 12'(nnn);
        4'hB: mpc = 12'((nnn + int'(mv[0])) % 4096);
        4'hC: mv[x] = 8'h00;
        4'hF: begin
          case (nn)
            'h1E: mi = 12'((int'(mi) + a) % 4096);
            'h33: begin
              mm[mi]                    = 8'(a / 100);
              mm[(int'(mi) + 1) % 4096] = 8'((a / 10) % 10);
              mm[(int'(mi) + 2) % 4096] = 8'(a % 10);
              mcyc += 3;
            end
            'h55: begin
              for (int k = 0; k <= x; k++) mm[(int'(mi) + k) % 4096] = mv[k];
              mcyc += x + 1;
            end
            'h65: begin
              for (int k = 0; k <= x; k++) mv[k] = mm[(int'(mi) + k) % 4096];
              mcyc += x + 2;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  endtask

  task automatic load_dut();
    for (int i = 0; i < 4096; i++) dut.mem0.data[i] = init_mem[i];
  endtask

  task automatic run_to_idle();
    dut_cyc = 0;
    while (dut.state != S_IDLE && dut_cyc < 20000) begin
      @(posedge clk); #1;
      dut_cyc++;
    end
  endtask

  // Load init_mem, reset, run DUT to halt and compare against the model.
  task automatic run_and_compare(input string name);
    int d;
    load_dut();
    model_run();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_to_idle();
    check({name, " cycles"}, dut_cyc, mcyc);
    check({name, " pc"}, int'(pc), int'(mpc));
    check({name, " I"}, int'(dut.addr), int'(mi));
    check({name, " sp"}, int'(dut.sp), int'(msp));
    d = 0;
    for (int i = 0; i < 4096; i++) if (dut.mem0.data[i] !== mm[i]) d++;
    check({name, " mem bytes differing"}, d, 0);
  endtask

  task automatic gen_random();
    int a, c;
    logic [3:0] rx, ry;
    int alu_n [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 14};
    fill_random();
    a = 12'h200;
    for (int k = 0; k < int'($urandom_range(6, 18)); k++) begin
      rx = 4'($urandom); ry = 4'($urandom);
      c = $urandom_range(0, 11);
      case (c)
        0:  begin put(a, {4'h6, rx, 8'($urandom)}); a += 2; end
        1:  begin put(a, {4'h7, rx, 8'($urandom)}); a += 2; end
        2, 3: begin
          put(a, {4'h8, rx, ry, 4'(alu_n[$urandom_range(0, 8)])}); a += 2;
        end
        4:  begin put(a, {4'hA, 12'($urandom_range(0, 12'h0F0))}); a += 2; end
        5:  begin
          put(a, {4'hA, 12'($urandom_range(0, 12'h0F0))});
          put(a + 2, {4'hF, rx, 8'h1E}); a += 4;
        end
        6:  begin
          // Conditional skip, always followed by a harmless instruction.
          case ($urandom_range(0, 3))
            0: put(a, {4'h3, rx, 8'($urandom_range(0, 3))});
            1: put(a, {4'h4, rx, 8'($urandom_range(0, 3))});
            2: put(a, {4'h5, rx, ry, 4'h0});
            default: put(a, {4'h9, rx, ry, 4'h0});
          endcase
          put(a + 2, {4'h6, ry, 8'($urandom)}); a += 4;
        end
`ifndef CPU_RAND_EN
        7:  begin put(a, {4'hC, rx, 8'($urandom)}); a += 2; end
`endif
        8, 9, 10: begin
          put(a, {4'hA, 12'($urandom_range(0, 12'h0F0))});
          put(a + 2, {4'hF, rx, (c == 8) ? 8'h33 : (c == 9) ? 8'h55 : 8'h65});
          a += 4;
        end
        default: begin
          put(a, ($urandom_range(0, 3) == 0) ? 16'h00E0 : {4'hD, 12'($urandom)});
          a += 2;
        end
      endcase
    end
    put(a, 16'hA000); put(a + 2, 16'hFF55); put(a + 4, 16'h0000);
  endtask

  initial begin
    // Reset state
    fill_random();
    load_dut();
    reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("reset pc", int'(pc), 12'h200);
    check("reset I", int'(dut.addr), 0);
    check("reset state", int'(dut.state), int'(S_FETCH_HI));
    check("reset sp", int'(dut.sp), 0);

    // Jump
    fill_random();
    put(12'h200, 16'h1206);
    put(12'h206, 16'h6042); put(12'h208, 16'hA020); put(12'h20A, 16'hF055); put(12'h20C, 16'h0000);
    run_and_compare("jump");
    check("jump mem020", int'(dut.mem0.data[12'h020]), 8'h42);
    check("jump pc", int'(pc), 12'h20E);

    // Call / return
    fill_random();
    put(12'h200, 16'h2208); put(12'h202, 16'h0000);
    put(12'h208, 16'h6042); put(12'h20A, 16'hA020); put(12'h20C, 16'hF055); put(12'h20E, 16'h00EE);
    run_and_compare("call");
    check("call mem020", int'(dut.mem0.data[12'h020]), 8'h42);
    check("call pc", int'(pc), 12'h204);
    check("call sp", int'(dut.sp), 0);

    // Add without carry
    fill_random();
    put(12'h200, 16'h6030); put(12'h202, 16'h7012); put(12'h204, 16'hA020);
    put(12'h206, 16'hF055); put(12'h208, 16'h0000);
    run_and_compare("add");
    check("add mem020", int'(dut.mem0.data[12'h020]), 8'h42);

    // Add with carry, then dump V0..VF to 0x020
    fill_random();
    put(12'h200, 16'h60FF); put(12'h202, 16'h6102); put(12'h204, 16'h8014);
    put(12'h206, 16'hA020); put(12'h208, 16'hFF55); put(12'h20A, 16'h0000);
    run_and_compare("carry");
    check("carry V0", int'(dut.mem0.data[12'h020]), 8'h01);
    check("carry VF", int'(dut.mem0.data[12'h02F]), 8'h01);

    // BNNN landing on the store sequence
    fill_random();
    put(12'h200, 16'h6004); put(12'h202, 16'hB208);
    put(12'h20C, 16'h6042); put(12'h20E, 16'hA020); put(12'h210, 16'hF055); put(12'h212, 16'h0000);
    run_and_compare("bnnn");
    check("bnnn mem020", int'(dut.mem0.data[12'h020]), 8'h42);

    // BNNN jumping past a store sequence at 0x208
    fill_random();
    put(12'h200, 16'h6004); put(12'h202, 16'hB208);
    put(12'h208, 16'h6042); put(12'h20A, 16'hA020); put(12'h20C, 16'hF055); put(12'h20E, 16'h0000);
    run_and_compare("bnnn skip");
    check("bnnn skip mem020", int'(dut.mem0.data[12'h020]), int'(init_mem[12'h020]));

    // Screen clear
    fill_random();
    for (int i = 12'h100; i < 12'h200; i++) init_mem[i] = 8'hFF;
    put(12'h200, 16'h00E0); put(12'h202, 16'h0000);
    run_and_compare("clear");
    check("clear cycles", dut_cyc, 3 + 256 + 3);
    begin
      int nz = 0;
      for (int i = 12'h100; i < 12'h200; i++) if (dut.mem0.data[i] != 8'h00) nz++;
      check("clear nonzero fb bytes", nz, 0);
    end
    check("clear mem0FF", int'(dut.mem0.data[12'h0FF]), int'(init_mem[12'h0FF]));
    check("clear mem200", int'(dut.mem0.data[12'h200]), 8'h00);

    // BCD
    fill_random();
    put(12'h200, 16'h60F3); put(12'h202, 16'hA020); put(12'h204, 16'hF033); put(12'h206, 16'h0000);
    run_and_compare("bcd");
    check("bcd hundreds", int'(dut.mem0.data[12'h020]), 2);
    check("bcd tens", int'(dut.mem0.data[12'h021]), 4);
    check("bcd units", int'(dut.mem0.data[12'h022]), 3);

    // Reset pulse in the middle of a screen clear
    fill_random();
    put(12'h200, 16'h00E0); put(12'h202, 16'h6042); put(12'h204, 16'hA020);
    put(12'h206, 16'hF055); put(12'h208, 16'h0000);
    load_dut();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset pc", int'(pc), 12'h200);
    check("midreset state", int'(dut.state), int'(S_FETCH_HI));
    check("midreset I", int'(dut.addr), 0);
    @(negedge clk);
    reset = 1'b0;
    run_to_idle();
    check("midreset idle reached", int'(dut.state), int'(S_IDLE));
    check("midreset mem020", int'(dut.mem0.data[12'h020]), 8'h42);

    // Randomised programs
    for (int t = 0; t < 25; t++) begin
      gen_random();
      run_and_compare($sformatf("rand%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
